// File: rtl/relogio_pkg.sv
// relogio_pkg
// Shared types and default constants for the digital-clock mode controller.
//   modo_t      : adjust/run mode encoding driven onto ctrl_relogio_modo
//   SEG_MAX_DEF : last seconds value before wrapping to 0
//   TIMEOUT_DEF : idle seconds before an adjust mode falls back to NORMAL
package relogio_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        AJ_HORA = 2'd1,
        AJ_MIN  = 2'd2
    } modo_t;

    localparam int unsigned SEG_MAX_DEF = 59;
    localparam int unsigned TIMEOUT_DEF = 30;

endpackage

// File: rtl/detector_borda.sv
// detector_borda
// One-bit rising-edge detector. Registers the previous level and reports a
// single-cycle pulse on the first cycle a level is seen high.
//   clk_i   : system clock
//   rst_ni  : synchronous active-low reset (clears the history register)
//   nivel_i : synchronized button level
//   borda_o : level & ~previous level
module detector_borda (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic nivel_i,
    output logic borda_o
);

    logic anterior_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            anterior_q <= 1'b0;
        end else begin
            anterior_q <= nivel_i;
        end
    end

    assign borda_o = nivel_i & ~anterior_q;

endmodule

// File: rtl/ctrl_relogio.sv
// ctrl_relogio
// Mode and sequencing controller for the digital clock. Keeps the seconds
// count, runs the NORMAL / AJ_HORA / AJ_MIN mode FSM, qualifies the minute
// and hour counter increments and drives the display blink flag.
//   ctrl_relogio_clock           : system clock
//   ctrl_relogio_reset           : synchronous active-low reset
//   ctrl_relogio_enable1hz       : one-cycle tick per second
//   ctrl_relogio_botao_modo      : mode button level (synchronized)
//   ctrl_relogio_botao_inc       : increment button level (synchronized)
//   ctrl_relogio_min_max         : minute counter is at 59
//   ctrl_relogio_incremento_min  : minute increment qualifier (combinational)
//   ctrl_relogio_incremento_hora : hour increment qualifier (combinational)
//   ctrl_relogio_segundos        : seconds, 0..SEG_MAX
//   ctrl_relogio_modo            : current mode
//   ctrl_relogio_piscar          : blink flag for the digits being adjusted
//
// state   | meaning
// NORMAL  | clock runs, seconds count, carries into minutes/hours
// AJ_HORA | seconds held at 0, inc button advances hours
// AJ_MIN  | seconds held at 0, inc button advances minutes
module ctrl_relogio
    import relogio_pkg::*;
#(
    parameter int unsigned SEG_MAX   = SEG_MAX_DEF,
    parameter int unsigned TIMEOUT_S = TIMEOUT_DEF
) (
    input  logic       ctrl_relogio_clock,
    input  logic       ctrl_relogio_reset,
    input  logic       ctrl_relogio_enable1hz,
    input  logic       ctrl_relogio_botao_modo,
    input  logic       ctrl_relogio_botao_inc,
    input  logic       ctrl_relogio_min_max,
    output logic       ctrl_relogio_incremento_min,
    output logic       ctrl_relogio_incremento_hora,
    output logic [5:0] ctrl_relogio_segundos,
    output logic [1:0] ctrl_relogio_modo,
    output logic       ctrl_relogio_piscar
);

    localparam int unsigned TW = $clog2(TIMEOUT_S + 1);

    modo_t         modo_q;
    logic [5:0]    segundos_q;
    logic          piscar_q;
    logic          pendente_q;
    logic [TW-1:0] timeout_q;

    logic press_modo;
    logic press_inc;
    logic tick;
    logic seg_fim;
    logic inc_ajuste;
    logic expirou;

    detector_borda u_borda_modo (
        .clk_i   (ctrl_relogio_clock),
        .rst_ni  (ctrl_relogio_reset),
        .nivel_i (ctrl_relogio_botao_modo),
        .borda_o (press_modo)
    );

    detector_borda u_borda_inc (
        .clk_i   (ctrl_relogio_clock),
        .rst_ni  (ctrl_relogio_reset),
        .nivel_i (ctrl_relogio_botao_inc),
        .borda_o (press_inc)
    );

    assign tick    = ctrl_relogio_enable1hz;
    assign seg_fim = (segundos_q == 6'(SEG_MAX));

    // A mode press on a tick wins over any pending increment.
    assign inc_ajuste = tick & (pendente_q | press_inc) & ~press_modo;

    // Last idle second of an adjust mode: a press in the same cycle rearms.
    assign expirou = tick & ~press_inc & (timeout_q == TW'(TIMEOUT_S - 1));

    always_comb begin
        ctrl_relogio_incremento_min  = 1'b0;
        ctrl_relogio_incremento_hora = 1'b0;
        if (ctrl_relogio_reset) begin
            case (modo_q)
                NORMAL: begin
                    ctrl_relogio_incremento_min  = tick & seg_fim;
                    ctrl_relogio_incremento_hora = tick & seg_fim & ctrl_relogio_min_max;
                end
                AJ_HORA: ctrl_relogio_incremento_hora = inc_ajuste;
                AJ_MIN:  ctrl_relogio_incremento_min  = inc_ajuste;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ctrl_relogio_clock) begin
        if (!ctrl_relogio_reset) begin
            modo_q     <= NORMAL;
            segundos_q <= '0;
            piscar_q   <= 1'b0;
            pendente_q <= 1'b0;
            timeout_q  <= '0;
        end else begin
            case (modo_q)
                NORMAL: begin
                    if (press_modo) begin
                        modo_q     <= AJ_HORA;
                        segundos_q <= '0;
                        pendente_q <= 1'b0;
                        timeout_q  <= '0;
                    end else if (tick) begin
                        segundos_q <= seg_fim ? '0 : segundos_q + 6'd1;
                    end
                end
                AJ_HORA, AJ_MIN: begin
                    segundos_q <= '0;
                    if (press_modo) begin
                        pendente_q <= 1'b0;
                        timeout_q  <= '0;
                        if (modo_q == AJ_HORA) begin
                            modo_q <= AJ_MIN;
                        end else begin
                            modo_q   <= NORMAL;
                            piscar_q <= 1'b0;
                        end
                    end else if (expirou) begin
                        modo_q     <= NORMAL;
                        piscar_q   <= 1'b0;
                        pendente_q <= 1'b0;
                        timeout_q  <= '0;
                    end else begin
                        if (tick) begin
                            piscar_q <= ~piscar_q;
                        end
                        if (press_inc) begin
                            // A press on a tick is consumed immediately.
                            pendente_q <= ~tick;
                            timeout_q  <= '0;
                        end else if (tick) begin
                            pendente_q <= 1'b0;
                            timeout_q  <= timeout_q + TW'(1);
                        end
                    end
                end
                default: begin
                    modo_q     <= NORMAL;
                    segundos_q <= '0;
                    piscar_q   <= 1'b0;
                    pendente_q <= 1'b0;
                    timeout_q  <= '0;
                end
            endcase
        end
    end

    assign ctrl_relogio_segundos = segundos_q;
    assign ctrl_relogio_modo     = modo_q;
    assign ctrl_relogio_piscar   = piscar_q;

endmodule

// File: doc/ctrl_relogio.md
Name: ctrl_relogio

Overview:
- Mode and sequencing controller for the digital-clock datapath.
- Holds the seconds count and the run/adjust mode FSM.
- Drives the increment-qualify inputs of the minute and hour counters, which advance only on cycles where the 1 Hz enable is high and their increment input is high.
- Sits between the user buttons and the minute/hour counters; also drives the display blink flag.

Parameters:
- SEG_MAX, 59, last seconds value before wrap to 0.
- TIMEOUT_S, 30, enable1hz ticks with no increment press before an adjust mode auto-returns to NORMAL.

Ports:
- ctrl_relogio_clock  in  1  system clock; all state updates on its rising edge.
- ctrl_relogio_reset  in  1  synchronous, active-low reset.
- ctrl_relogio_enable1hz  in  1  one-cycle tick, once per second.
- ctrl_relogio_botao_modo  in  1  mode button level; already synchronized, active-high.
- ctrl_relogio_botao_inc  in  1  increment button level; already synchronized, active-high.
- ctrl_relogio_min_max  in  1  high when the minute counter reads 59.
- ctrl_relogio_incremento_min  out  1  increment qualifier to the minute counter.
- ctrl_relogio_incremento_hora  out  1  increment qualifier to the hour counter.
- ctrl_relogio_segundos  out  6  binary seconds, 0..SEG_MAX.
- ctrl_relogio_modo  out  2  current mode: 0 NORMAL, 1 AJ_HORA, 2 AJ_MIN.
- ctrl_relogio_piscar  out  1  display blink flag for the digits being adjusted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Reset is sampled only on the rising clock edge, while ctrl_relogio_reset == 0.
- Reset values: mode = NORMAL, segundos = 0, piscar = 0, pending = 0, timeout count = 0, both button-history registers = 0.
- Incremento outputs under reset: the incremento outputs are combinational and are forced to 0 while reset is asserted.
- Edge detect: press = level & ~previous level, using a registered previous level for each button. Holding a button produces exactly one press.
- FSM transitions (mode press): NORMAL -> AJ_HORA -> AJ_MIN -> NORMAL.
  - Every mode transition clears pending and the timeout count.
  - Entering NORMAL from an adjust mode sets segundos to 0 and piscar to 0.
- NORMAL, on an enable1hz cycle:
  - segundos increments, wrapping SEG_MAX -> 0.
  - incremento_min = enable1hz & (segundos == SEG_MAX).
  - incremento_hora = enable1hz & (segundos == SEG_MAX) & min_max.
  - Both outputs are combinational from registered state plus inputs, so the counters sample them on the same edge as the tick.
  - The inc button is ignored.
- AJ_HORA / AJ_MIN:
  - segundos is held at 0.
  - An inc press sets pending and clears the timeout count.
  - The selected output = enable1hz & (pending | inc press); the other output = 0. Pending clears on that tick.
  - A press on the same cycle as the tick increments on that tick and leaves pending = 0.
  - Multiple presses between ticks yield a single increment.
  - piscar toggles on each enable1hz.
- Timeout:
  - Each enable1hz with no press in that cycle increments the timeout count.
  - When the count reaches TIMEOUT_S, the FSM returns to NORMAL on that edge, with the NORMAL-entry effects.
- Priority in a single cycle: reset > mode press > timeout > inc press.
  - A mode press on a tick cycle in an adjust mode suppresses that tick's increment.
- Reset mid-adjust: returns to NORMAL on the next edge; any pending press is discarded.
- Undefined mode encoding 3: recovers to NORMAL on the next edge.

Decomposition:
- Package relogio_pkg:
  - typedef enum logic [1:0] modo_t {NORMAL, AJ_HORA, AJ_MIN}.
  - Constants SEG_MAX_DEF = 59 and TIMEOUT_DEF = 30.
- Sub-module detector_borda: a one-bit registered rising-edge detector using the same clock/reset convention. It is instantiated twice, once per button.

Test Plan:
1. Reset held 3 cycles, then released with 60 enable1hz ticks and min_max = 0 -> segundos counts 0..59 then 0; incremento_min is high only on the tick where segundos == 59; incremento_hora stays 0.
2. segundos == 59 and min_max = 1 on a tick -> incremento_min = 1 and incremento_hora = 1 in that same cycle; segundos becomes 0.
3. One mode press, then 3 inc presses between two ticks -> modo = 1; incremento_hora pulses once on the next tick; incremento_min = 0 throughout; segundos = 0.
4. An inc press on the same cycle as enable1hz in AJ_MIN -> incremento_min = 1 that cycle; pending = 0 afterward; no increment on the following tick.
5. Enter AJ_HORA and apply 30 ticks with no presses -> modo = 0 after the 30th tick; piscar = 0; segundos = 0.
6. Reset asserted in AJ_MIN with pending = 1 -> next edge gives modo = 0, segundos = 0, piscar = 0; no incremento pulse on the subsequent tick.
